// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master. Each accepted command becomes one AXI read
// or write, and the next command is not accepted until the response is consumed.
module axi_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic [STRB_WIDTH-1:0] WSTRB,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  output logic                  RREADY
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
  } req_t;

  typedef struct packed {
    logic                  write;
    logic [1:0]            resp;
    logic [DATA_WIDTH-1:0] rdata;
  } rsp_t;

  state_t state, state_nxt;
  req_t   req_q, req_nxt;
  rsp_t   rsp_q, rsp_nxt;
  logic   aw_done, aw_done_nxt, w_done, w_done_nxt;
  logic   ready_q, ready_nxt;
  logic   arvalid_q, arvalid_nxt, rready_q, rready_nxt;
  logic   awvalid_q, awvalid_nxt, wvalid_q, wvalid_nxt;
  logic   bready_q, bready_nxt, rsp_valid_q, rsp_valid_nxt;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state       <= IDLE;
      req_q       <= '0;
      rsp_q       <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      ready_q     <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      req_q       <= req_nxt;
      rsp_q       <= rsp_nxt;
      aw_done     <= aw_done_nxt;
      w_done      <= w_done_nxt;
      ready_q     <= ready_nxt;
      arvalid_q   <= arvalid_nxt;
      rready_q    <= rready_nxt;
      awvalid_q   <= awvalid_nxt;
      wvalid_q    <= wvalid_nxt;
      bready_q    <= bready_nxt;
      rsp_valid_q <= rsp_valid_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    req_nxt     = req_q;
    rsp_nxt     = rsp_q;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    case (state)
      IDLE: begin
        if (cmd_valid && ready_q) begin
          req_nxt     = '{addr: cmd_addr, wdata: cmd_wdata, wstrb: cmd_wstrb};
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          state_nxt   = cmd_write ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: if (arvalid_q && ARREADY) state_nxt = RD_DATA;
      RD_DATA: begin
        if (RVALID && rready_q) begin
          rsp_nxt.write = 1'b0;
          rsp_nxt.resp  = RRESP;
          rsp_nxt.rdata = RDATA;
          state_nxt     = RSP;
        end
      end
      WR_REQ: begin
        // AW and W complete independently, in either order or together
        if (awvalid_q && AWREADY) aw_done_nxt = 1'b1;
        if (wvalid_q && WREADY)   w_done_nxt  = 1'b1;
        if (aw_done_nxt && w_done_nxt) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        if (BVALID && bready_q) begin
          rsp_nxt.write = 1'b1;
          rsp_nxt.resp  = BRESP;
          rsp_nxt.rdata = '0;
          state_nxt     = RSP;
        end
      end
      RSP:     if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Handshake outputs are registered from the next state so they change only on edges
    ready_nxt     = (state_nxt == IDLE);
    arvalid_nxt   = (state_nxt == RD_ADDR);
    rready_nxt    = (state_nxt == RD_DATA);
    awvalid_nxt   = (state_nxt == WR_REQ) && !aw_done_nxt;
    wvalid_nxt    = (state_nxt == WR_REQ) && !w_done_nxt;
    bready_nxt    = (state_nxt == WR_RESP);
    rsp_valid_nxt = (state_nxt == RSP);
  end

  assign cmd_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_q.write;
  assign rsp_rdata = rsp_q.rdata;
  assign rsp_resp  = rsp_q.resp;
  assign AWADDR    = req_q.addr;
  assign ARADDR    = req_q.addr;
  assign WDATA     = req_q.wdata;
  assign WSTRB     = req_q.wstrb;
  assign AWVALID   = awvalid_q;
  assign WVALID    = wvalid_q;
  assign BREADY    = bready_q;
  assign ARVALID   = arvalid_q;
  assign RREADY    = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a delay-configurable AXI-Lite slave plus a word-array
// reference model of the memory, with randomized transactions.
module tb_axi_lite_master;
  localparam int AW = 32, DW = 32, SW = 4;

  logic ACLK = 0, ARESET = 1;
  always #5 ACLK = ~ACLK;

  logic cmd_valid = 0, cmd_write = 0, rsp_ready = 1;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic cmd_ready, rsp_valid, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [AW-1:0] AWADDR, ARADDR;
  logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [SW-1:0] WSTRB;
  logic [1:0] BRESP, RRESP;

  axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  int passed = 0, total = 0, busy_err = 0;

  // slave delays and response codes, set by the stimulus between transactions
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] bresp_code = 2'b00, rresp_code = 2'b00;

  logic [DW-1:0] ref_mem [0:63];
  logic [DW-1:0] smem [0:63];
  bit mem_inited = 0;
  logic aw_have, w_have, ar_have;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [DW-1:0] s_wdata;
  logic [SW-1:0] s_wstrb;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;

  // AXI-Lite slave: each READY rises after VALID has been seen for its delay in cycles
  always @(posedge ACLK) begin
    if (ARESET) begin
      AWREADY <= 0; WREADY <= 0; BVALID <= 0; ARREADY <= 0; RVALID <= 0;
      BRESP <= 0; RRESP <= 0; RDATA <= 0;
      aw_have <= 0; w_have <= 0; ar_have <= 0;
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      if (!mem_inited) begin
        for (int i = 0; i < 64; i++) smem[i] <= 32'h5A5A_0000 + i;
        mem_inited <= 1;
      end
    end else begin
      if (AWVALID && AWREADY) begin
        AWREADY <= 0; aw_have <= 1; s_awaddr <= AWADDR; aw_cnt <= 0; n_aw <= n_aw + 1;
      end else if (AWVALID && !aw_have) begin
        if (aw_cnt >= aw_dly) AWREADY <= 1; else aw_cnt <= aw_cnt + 1;
      end
      if (WVALID && WREADY) begin
        WREADY <= 0; w_have <= 1; s_wdata <= WDATA; s_wstrb <= WSTRB; w_cnt <= 0; n_w <= n_w + 1;
      end else if (WVALID && !w_have) begin
        if (w_cnt >= w_dly) WREADY <= 1; else w_cnt <= w_cnt + 1;
      end
      if (BVALID && BREADY) begin
        BVALID <= 0; aw_have <= 0; w_have <= 0; n_b <= n_b + 1;
      end else if (aw_have && w_have && !BVALID) begin
        if (b_cnt >= b_dly) begin
          BVALID <= 1; BRESP <= bresp_code; b_cnt <= 0;
          for (int i = 0; i < SW; i++)
            if (s_wstrb[i]) smem[s_awaddr[7:2]][8*i +: 8] <= s_wdata[8*i +: 8];
        end else b_cnt <= b_cnt + 1;
      end
      if (ARVALID && ARREADY) begin
        ARREADY <= 0; ar_have <= 1; s_araddr <= ARADDR; ar_cnt <= 0; n_ar <= n_ar + 1;
      end else if (ARVALID && !ar_have) begin
        if (ar_cnt >= ar_dly) ARREADY <= 1; else ar_cnt <= ar_cnt + 1;
      end
      if (RVALID && RREADY) begin
        RVALID <= 0; ar_have <= 0; n_r <= n_r + 1;
      end else if (ar_have && !RVALID) begin
        if (r_cnt >= r_dly) begin
          RVALID <= 1; RDATA <= smem[s_araddr[7:2]]; RRESP <= rresp_code; r_cnt <= 0;
        end else r_cnt <= r_cnt + 1;
      end
    end
  end

  // protocol monitor: a pending VALID must hold with stable payload unless reset intervened
  int proto_err = 0, bready_early = 0, aw_only = 0, n_rsp = 0;
  logic p_rst = 1, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
  logic [AW-1:0] p_awaddr = '0, p_araddr = '0;
  logic [DW-1:0] p_wdata = '0;
  always @(posedge ACLK) begin
    if (!p_rst && !ARESET) begin
      if (p_awv && !p_awr && (!AWVALID || AWADDR !== p_awaddr)) proto_err <= proto_err + 1;
      if (p_wv && !p_wr && (!WVALID || WDATA !== p_wdata)) proto_err <= proto_err + 1;
      if (p_arv && !p_arr && (!ARVALID || ARADDR !== p_araddr)) proto_err <= proto_err + 1;
      if (BREADY && !(aw_have && w_have)) bready_early <= bready_early + 1;
      if (AWVALID && !WVALID) aw_only <= aw_only + 1;
      if (rsp_valid && rsp_ready) n_rsp <= n_rsp + 1;
    end
    p_rst <= ARESET; p_awv <= AWVALID; p_awr <= AWREADY; p_wv <= WVALID; p_wr <= WREADY;
    p_arv <= ARVALID; p_arr <= ARREADY; p_awaddr <= AWADDR; p_araddr <= ARADDR; p_wdata <= WDATA;
  end

  task automatic set_dly(input int aw, input int w, input int b, input int ar, input int r);
    aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
  endtask

  task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s);
    int n = 0;
    @(negedge ACLK);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 100) begin @(negedge ACLK); n++; end
    total++;
    if (cmd_ready !== 1'b1) $display("FAIL cmd_accept: cmd_ready=%b required 1 within 100 cycles", cmd_ready);
    else passed++;
    @(posedge ACLK); #1 cmd_valid = 0;
  endtask

  // called just after the accepting edge; cmd_ready must stay low until the response
  task automatic wait_rsp(output logic ok, output int lat);
    int n = 0;
    while (!rsp_valid && n < 200) begin
      if (cmd_ready !== 1'b0) busy_err++;
      @(negedge ACLK); n++;
    end
    if (cmd_ready !== 1'b0) busy_err++;
    ok = rsp_valid;
    lat = n - 1;
  endtask

  task automatic txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [SW-1:0] s, input string tag);
    logic ok;
    int lat;
    logic [DW-1:0] exp_d;
    logic [1:0] exp_r;
    send_cmd(w, a, d, s);
    wait_rsp(ok, lat);
    total++;
    if (!ok) $display("FAIL %s_timeout: rsp_valid=%b required 1", tag, rsp_valid);
    else begin
      passed++;
      exp_r = w ? bresp_code : rresp_code;
      exp_d = w ? '0 : ref_mem[a[7:2]];
      total++;
      if (rsp_write !== w || rsp_resp !== exp_r || rsp_rdata !== exp_d)
        $display("FAIL %s: write=%b resp=%b rdata=%h required write=%b resp=%b rdata=%h",
                 tag, rsp_write, rsp_resp, rsp_rdata, w, exp_r, exp_d);
      else passed++;
      if (w) for (int i = 0; i < SW; i++) if (s[i]) ref_mem[a[7:2]][8*i +: 8] = d[8*i +: 8];
    end
    @(posedge ACLK); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge ACLK);
    total++;
    if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready: got %b required 0", cmd_ready); else passed++;
    total++;
    if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid} !== 6'b0)
      $display("FAIL reset_valids: got %b required 000000", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid});
    else passed++;
    total++;
    if (rsp_rdata !== '0 || rsp_resp !== 2'b0 || rsp_write !== 1'b0 || AWADDR !== '0 || WDATA !== '0 || WSTRB !== '0)
      $display("FAIL reset_regs: rdata=%h resp=%b write=%b addr=%h wdata=%h wstrb=%h required all 0",
               rsp_rdata, rsp_resp, rsp_write, AWADDR, WDATA, WSTRB);
    else passed++;
    ARESET = 0;
    @(negedge ACLK);
    total++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready: got %b required 1", cmd_ready); else passed++;
  endtask

  task automatic test_basic();
    logic ok;
    int lat;
    set_dly(0, 0, 0, 0, 0);
    txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, "basic_write");
    send_cmd(1'b0, 32'h10, '0, '0);
    wait_rsp(ok, lat);
    total++;
    if (!ok || rsp_rdata !== 32'hDEAD_BEEF || rsp_resp !== 2'b00 || rsp_write !== 1'b0)
      $display("FAIL basic_read: valid=%b rdata=%h resp=%b write=%b required 1 deadbeef 00 0",
               rsp_valid, rsp_rdata, rsp_resp, rsp_write);
    else passed++;
    total++;
    if (lat !== 4) $display("FAIL read_latency: got %0d cycles required 4", lat); else passed++;
    @(posedge ACLK); #1;
  endtask

  task automatic test_w_before_aw();
    int nb0, ao0;
    nb0 = n_b; ao0 = aw_only;
    set_dly(4, 0, 0, 0, 0);
    txn(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, "w_first_write");
    total++;
    if (n_b !== nb0 + 1) $display("FAIL w_first_bcount: got %0d required %0d", n_b, nb0 + 1); else passed++;
    total++;
    if (aw_only - ao0 < 3) $display("FAIL w_first_aw_hold: aw-only cycles %0d required >=3", aw_only - ao0);
    else passed++;
    total++;
    if (bready_early !== 0) $display("FAIL bready_early: got %0d required 0", bready_early); else passed++;
    set_dly(0, 0, 0, 0, 0);
    txn(1'b0, 32'h20, '0, '0, "w_first_readback");
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    for (int i = 0; i < 8; i++) begin
      set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
      d = i * 32'h1111_1111;
      txn(1'b1, i * 4, d, 4'hF, "b2b_write");
    end
    for (int i = 0; i < 8; i++) begin
      set_dly(0, 0, 0, $urandom_range(0, 3), $urandom_range(0, 3));
      txn(1'b0, i * 4, '0, '0, "b2b_read");
    end
    total++;
    if (busy_err !== 0) $display("FAIL b2b_cmd_ready_busy: violations %0d required 0", busy_err); else passed++;
  endtask

  task automatic test_rsp_stall();
    logic ok;
    int lat, ar0, n;
    set_dly(0, 0, 0, 0, 0);
    rsp_ready = 0;
    send_cmd(1'b0, 32'h04, '0, '0);
    wait_rsp(ok, lat);
    @(negedge ACLK);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h08;
    ar0 = n_ar;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== ref_mem[1] || rsp_resp !== 2'b00 || cmd_ready !== 1'b0 ||
          ARVALID !== 1'b0 || n_ar !== ar0)
        $display("FAIL stall_hold: valid=%b rdata=%h resp=%b cmd_ready=%b arvalid=%b ars=%0d required 1 %h 00 0 0 %0d",
                 rsp_valid, rsp_rdata, rsp_resp, cmd_ready, ARVALID, n_ar, ref_mem[1], ar0);
      else passed++;
      if (c < 4) @(negedge ACLK);
    end
    rsp_ready = 1;
    n = 0;
    @(negedge ACLK);
    while (!cmd_ready && n < 100) begin @(negedge ACLK); n++; end
    @(posedge ACLK); #1 cmd_valid = 0;
    wait_rsp(ok, lat);
    total++;
    if (!ok || rsp_rdata !== ref_mem[2] || rsp_write !== 1'b0)
      $display("FAIL stall_next_read: valid=%b rdata=%h required 1 %h", rsp_valid, rsp_rdata, ref_mem[2]);
    else passed++;
    @(posedge ACLK); #1;
  endtask

  task automatic test_errors();
    set_dly(0, 0, 0, 0, 0);
    rresp_code = 2'b10;
    txn(1'b0, 32'h0C, '0, '0, "err_read");
    total++;
    if (rsp_resp !== 2'b10) $display("FAIL err_rresp: got %b required 10", rsp_resp); else passed++;
    bresp_code = 2'b11;
    txn(1'b1, 32'h30, 32'h0BAD_0BAD, 4'h3, "err_write");
    total++;
    if (rsp_resp !== 2'b11) $display("FAIL err_bresp: got %b required 11", rsp_resp); else passed++;
    @(negedge ACLK);
    total++;
    if (cmd_ready !== 1'b1) $display("FAIL err_idle: cmd_ready=%b required 1", cmd_ready); else passed++;
    rresp_code = 2'b00; bresp_code = 2'b00;
  endtask

  task automatic test_abort();
    int r0, seen;
    set_dly(20, 0, 0, 0, 0);
    send_cmd(1'b1, 32'h00, 32'h1234_5678, 4'hF);
    @(negedge ACLK); @(negedge ACLK);
    total++;
    if (AWVALID !== 1'b1) $display("FAIL abort_pre_awvalid: got %b required 1", AWVALID); else passed++;
    r0 = n_rsp;
    ARESET = 1;
    @(negedge ACLK);
    ARESET = 0;
    total++;
    if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, cmd_ready} !== 7'b0 || AWADDR !== '0 || WDATA !== '0)
      $display("FAIL abort_outputs: valids=%b cmd_ready=%b awaddr=%h wdata=%h required all 0",
               {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}, cmd_ready, AWADDR, WDATA);
    else passed++;
    @(negedge ACLK);
    total++;
    if (cmd_ready !== 1'b1) $display("FAIL abort_ready: got %b required 1", cmd_ready); else passed++;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid) seen++;
      @(negedge ACLK);
    end
    total++;
    if (seen !== 0 || n_rsp !== r0) $display("FAIL abort_no_rsp: rsp cycles %0d required 0", seen); else passed++;
    set_dly(0, 0, 0, 0, 0);
    txn(1'b0, 32'h00, '0, '0, "abort_read");
  endtask

  task automatic test_random();
    logic w;
    logic [AW-1:0] a;
    for (int i = 0; i < 40; i++) begin
      set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
      bresp_code = 2'($urandom_range(0, 3));
      rresp_code = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 15)) * 4;
      txn(w, a, $urandom, 4'($urandom_range(0, 15)), "rand");
    end
    rresp_code = 2'b00; bresp_code = 2'b00;
    total++;
    if (proto_err !== 0) $display("FAIL axi_valid_stable: violations %0d required 0", proto_err); else passed++;
    total++;
    if (bready_early !== 0 || busy_err !== 0)
      $display("FAIL ordering: bready_early=%0d busy=%0d required 0 0", bready_early, busy_err);
    else passed++;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h5A5A_0000 + i;
    test_reset();
    test_basic();
    test_w_before_aw();
    test_back_to_back();
    test_rsp_stall();
    test_errors();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end
endmodule
